// File: rtl/dram_pkg.sv
// Shared encodings for the byte-serial cache-to-DRAM request protocol.
// Both the Cache and the DRAM responder import this package.
package dram_pkg;

    typedef enum logic [1:0] {
        DRAM_IDLE  = 2'b00,
        DRAM_READ  = 2'b01,
        DRAM_WRITE = 2'b10,
        DRAM_RSVD  = 2'b11
    } dram_signal_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } dram_state_e;

    typedef logic [7:0] dram_byte_t;

    // Wide enough for the largest legal LATENCY (255).
    localparam int CNT_BITS = 8;

endpackage

// File: rtl/dram_byte_array.sv
// Byte storage behind the DRAM responder: synchronous writes, combinational read.
// Protocol write port has priority over the backdoor port on an address collision.
module dram_byte_array
    import dram_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 proto_we,
    input  logic [ADDR_BITS-1:0] proto_addr,
    input  dram_byte_t           proto_data,
    input  logic                 load_we,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  dram_byte_t           load_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output dram_byte_t           rd_data
);

    dram_byte_t mem [2**ADDR_BITS];

    logic load_blocked;
    assign load_blocked = proto_we && (proto_addr == load_addr);

    always_ff @(posedge clk) begin
        if (load_we && !load_blocked) begin
            mem[load_addr] <= load_data;
        end
        if (proto_we) begin
            mem[proto_addr] <= proto_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dram_byte_responder.sv
// Memory-side responder for byte-serial cache requests: fixed latency, four-phase handshake.
// Optional DRAM_STATS_EN adds rd_count, wr_count and rsvd_seen outputs.
//
// state | meaning
// IDLE  | waiting for a read/write request on dram_signal
// BUSY  | request latched, latency counter running down to zero
// HOLD  | dram_ready high, waiting for dram_signal to return to idle
module dram_byte_responder
    import dram_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  dram_signal,
    input  logic [31:0] dram_addr_rd,
    input  logic [31:0] dram_addr_wr,
    input  logic [7:0]  dram_write_data,
    output logic        dram_ready,
    output logic [7:0]  dram_result,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [7:0]  load_data
`ifdef DRAM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [0:0]  rsvd_seen
`endif
);

    dram_signal_e         sig;
    dram_state_e          state, state_d;
    logic [CNT_BITS-1:0]  cnt, cnt_d;
    logic                 accept, done;
    logic                 op_wr;
    logic [ADDR_BITS-1:0] addr_q;
    dram_byte_t           data_q;
    dram_byte_t           rd_data;
    logic                 commit_wr;

    assign sig = dram_signal_e'(dram_signal);

    // Upper request address bits are intentionally dropped so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dram_addr_rd[31:ADDR_BITS], dram_addr_wr[31:ADDR_BITS],
                                load_addr[31:ADDR_BITS]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (sig == DRAM_READ || sig == DRAM_WRITE) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_BITS'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    done    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (sig == DRAM_IDLE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are held only while BUSY, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_wr  <= (sig == DRAM_WRITE);
            addr_q <= (sig == DRAM_WRITE) ? dram_addr_wr[ADDR_BITS-1:0]
                                          : dram_addr_rd[ADDR_BITS-1:0];
            data_q <= dram_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dram_ready  <= 1'b0;
            dram_result <= 8'h00;
        end else if (done) begin
            dram_ready  <= 1'b1;
            dram_result <= op_wr ? data_q : rd_data;
        end else if (state == HOLD && state_d == IDLE) begin
            dram_ready  <= 1'b0;
        end
    end

    // A reset landing on the final BUSY cycle must not commit the write.
    assign commit_wr = done && op_wr && !rst;

    dram_byte_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk        (clk),
        .proto_we   (commit_wr),
        .proto_addr (addr_q),
        .proto_data (data_q),
        .load_we    (load_en),
        .load_addr  (load_addr[ADDR_BITS-1:0]),
        .load_data  (load_data),
        .rd_addr    (addr_q),
        .rd_data    (rd_data)
    );

`ifdef DRAM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count  <= '0;
            wr_count  <= '0;
            rsvd_seen <= 1'b0;
        end else begin
            if (done) begin
                if (op_wr) begin
                    wr_count <= wr_count + 32'd1;
                end else begin
                    rd_count <= rd_count + 32'd1;
                end
            end
            if (state == IDLE && sig == DRAM_RSVD) begin
                rsvd_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dram_byte_responder.sv
// Directed scoreboard bench for dram_byte_responder (LATENCY=4, ADDR_BITS=12).
module tb_dram_byte_responder;

    localparam int LATENCY   = 4;
    localparam int ADDR_BITS = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dram_signal;
    logic [31:0] dram_addr_rd;
    logic [31:0] dram_addr_wr;
    logic [7:0]  dram_write_data;
    logic        dram_ready;
    logic [7:0]  dram_result;
    logic        load_en;
    logic [31:0] load_addr;
    logic [7:0]  load_data;
`ifdef DRAM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic [0:0]  rsvd_seen;
`endif

    int n_vec = 0;
    int n_err = 0;
    int rd_exp = 0;
    int wr_exp = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    dram_byte_responder #(
        .ADDR_BITS (ADDR_BITS),
        .LATENCY   (LATENCY)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dram_signal     (dram_signal),
        .dram_addr_rd    (dram_addr_rd),
        .dram_addr_wr    (dram_addr_wr),
        .dram_write_data (dram_write_data),
        .dram_ready      (dram_ready),
        .dram_result     (dram_result),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_data       (load_data)
`ifdef DRAM_STATS_EN
        ,
        .rd_count        (rd_count),
        .wr_count        (wr_count),
        .rsvd_seen       (rsvd_seen)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic backdoor(input logic [31:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        cyc();
        load_en   = 1'b0;
    endtask

    // Issue one request, push its expected byte, and check latency, result and release.
    task automatic do_req(input logic [1:0] sig, input logic [31:0] addr, input logic [7:0] wdata,
                          input logic [7:0] expv, input int hold_extra,
                          input bit move_addr, input bit bd_collide);
        int n;
        logic [7:0] want;
        dram_signal = sig;
        if (sig == 2'b01) dram_addr_rd = addr;
        else              dram_addr_wr = addr;
        dram_write_data = wdata;
        exp_q.push_back(expv);
        cyc();
        if (move_addr) dram_addr_rd = addr ^ 32'h15;
        n = 0;
        while (!dram_ready && n < 20) begin
            if (bd_collide && n == LATENCY - 1) begin
                load_en   = 1'b1;
                load_addr = addr;
                load_data = 8'h22;
            end
            cyc();
            n++;
        end
        load_en = 1'b0;
        chk("latency", n, LATENCY);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            want = 8'h00;
        end else begin
            want = exp_q.pop_front();
        end
        chk("result", dram_result, want);
        if (sig == 2'b01) rd_exp++;
        else              wr_exp++;
        for (int i = 0; i < hold_extra; i++) begin
            cyc();
            chk("hold_ready", dram_ready, 1'b1);
            chk("hold_result", dram_result, want);
        end
        dram_signal = 2'b00;
        cyc();
        chk("release_ready", dram_ready, 1'b0);
        chk("release_result", dram_result, want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        dram_signal = 2'b00;
        dram_addr_rd = '0;
        dram_addr_wr = '0;
        dram_write_data = '0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        @(negedge clk);
        // Backdoor loads are accepted while reset is asserted.
        backdoor(32'h005, 8'hA5);
        backdoor(32'h020, 8'h11);
        rst = 1'b0;
        cyc();
        chk("reset_ready", dram_ready, 1'b0);
        chk("reset_result", dram_result, 8'h00);

        // 1: basic read of a backdoor-loaded byte
        do_req(2'b01, 32'h005, 8'h00, 8'hA5, 0, 1'b0, 1'b0);
        // 2: write echo, then read back
        do_req(2'b10, 32'h010, 8'h3C, 8'h3C, 0, 1'b0, 1'b0);
        do_req(2'b01, 32'h010, 8'h00, 8'h3C, 0, 1'b0, 1'b0);
        // 3: address wrap
        do_req(2'b10, 32'h0000_1003, 8'h77, 8'h77, 0, 1'b0, 1'b0);
        do_req(2'b01, 32'h003, 8'h00, 8'h77, 0, 1'b0, 1'b0);

        // 4: reset mid-write aborts without committing
        dram_signal = 2'b10;
        dram_addr_wr = 32'h020;
        dram_write_data = 8'hFF;
        cyc();
        cyc();
        rst = 1'b1;
        dram_signal = 2'b00;
        cyc();
        rst = 1'b0;
        rd_exp = 0;
        wr_exp = 0;
        chk("abort_ready", dram_ready, 1'b0);
        chk("abort_result", dram_result, 8'h00);
        for (int i = 0; i < LATENCY + 2; i++) cyc();
        chk("abort_ready_later", dram_ready, 1'b0);
        do_req(2'b01, 32'h020, 8'h00, 8'h11, 0, 1'b0, 1'b0);

        // 5: request held through HOLD, address moved during BUSY
        do_req(2'b01, 32'h005, 8'h00, 8'hA5, 3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc();
        chk("no_second_access", dram_ready, 1'b0);
        dram_signal = 2'b11;
        for (int i = 0; i < LATENCY + 2; i++) cyc();
        chk("rsvd_no_response", dram_ready, 1'b0);
        dram_signal = 2'b00;
        cyc();
`ifdef DRAM_STATS_EN
        chk("rsvd_seen", rsvd_seen, 1'b1);
        chk("rsvd_rd_count", rd_count, rd_exp);
        chk("rsvd_wr_count", wr_count, wr_exp);
`endif

        // 6: backdoor and protocol write to the same address on the same edge
        do_req(2'b10, 32'h030, 8'h99, 8'h99, 0, 1'b0, 1'b1);
        do_req(2'b01, 32'h030, 8'h00, 8'h99, 0, 1'b0, 1'b0);
        do_req(2'b01, 32'h003, 8'h00, 8'h77, 0, 1'b0, 1'b0);
        do_req(2'b10, 32'h031, 8'h5A, 8'h5A, 0, 1'b0, 1'b0);
`ifdef DRAM_STATS_EN
        chk("final_rd_count", rd_count, rd_exp);
        chk("final_wr_count", wr_count, wr_exp);
`endif
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
